// File: rtl/modular_log.sv
// Brute-force discrete logarithm: finds the smallest x in [0, P-2] with base^x mod P == target.
// One modular multiply and one compare per enabled clock.
module modular_log #(
    parameter int N = 8,
    parameter int P = 89
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         ena,
    input  logic         start,
    input  logic [N-1:0] base,
    input  logic [N-1:0] target,
    output logic [N-1:0] res,
    output logic         found,
    output logic         rdy,
    output logic         busy
);

    typedef enum logic [1:0] {
        IDLE,
        INIT,
        SEARCH
    } state_t;

    localparam logic [N-1:0]   P_N   = N'(P);
    localparam logic [N-1:0]   LIMIT = N'(P - 2);
    localparam logic [2*N-1:0] P_W   = (2 * N)'(P);

    state_t         state_q, state_d;
    logic [N-1:0]   base_q,  base_d;
    logic [N-1:0]   tgt_q,   tgt_d;
    logic [N-1:0]   acc_q,   acc_d;
    logic [N-1:0]   cnt_q,   cnt_d;
    logic [N-1:0]   res_q,   res_d;
    logic           found_q, found_d;
    logic           rdy_q,   rdy_d;
    logic [2*N-1:0] prod;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            base_q  <= '0;
            tgt_q   <= '0;
            acc_q   <= '0;
            cnt_q   <= '0;
            res_q   <= '0;
            found_q <= 1'b0;
            rdy_q   <= 1'b0;
        end else if (ena) begin
            state_q <= state_d;
            base_q  <= base_d;
            tgt_q   <= tgt_d;
            acc_q   <= acc_d;
            cnt_q   <= cnt_d;
            res_q   <= res_d;
            found_q <= found_d;
            rdy_q   <= rdy_d;
        end
    end

    // Full 2N-bit product so the reduction never sees a truncated value.
    always_comb begin
        prod = {{N{1'b0}}, acc_q} * {{N{1'b0}}, base_q};
    end

    always_comb begin
        state_d = state_q;
        base_d  = base_q;
        tgt_d   = tgt_q;
        acc_d   = acc_q;
        cnt_d   = cnt_q;
        res_d   = res_q;
        found_d = found_q;
        rdy_d   = 1'b0;

        case (state_q)
            IDLE: begin
                if (start) begin
                    state_d = INIT;
                end
            end
            INIT: begin
                base_d  = base % P_N;
                tgt_d   = target % P_N;
                acc_d   = N'(1);
                cnt_d   = '0;
                state_d = SEARCH;
            end
            SEARCH: begin
                // Match is tested before the limit so x = P-2 can still be reported.
                if (acc_q == tgt_q) begin
                    res_d   = cnt_q;
                    found_d = 1'b1;
                    rdy_d   = 1'b1;
                    state_d = IDLE;
                end else if (cnt_q == LIMIT) begin
                    res_d   = '0;
                    found_d = 1'b0;
                    rdy_d   = 1'b1;
                    state_d = IDLE;
                end else begin
                    acc_d = N'(prod % P_W);
                    cnt_d = cnt_q + N'(1);
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    assign res   = res_q;
    assign found = found_q;
    assign rdy   = rdy_q;
    assign busy  = (state_q != IDLE);

endmodule

// File: tb/tb_modular_log.sv
// Self-checking bench for modular_log (N=8, P=89): vector table, scoreboard queue,
// hand-written sequences for ena stalls, busy-time start and mid-search reset.
module tb_modular_log;

    localparam int N = 8;
    localparam int P = 89;

    logic         clk;
    logic         rst;
    logic         ena;
    logic         start;
    logic [N-1:0] base;
    logic [N-1:0] target;
    logic [N-1:0] res;
    logic         found;
    logic         rdy;
    logic         busy;

    int checks = 0;
    int errors = 0;

    typedef struct {
        logic [N-1:0] b;
        logic [N-1:0] t;
        int           res;
        int           found;
        int           lat;
    } vec_t;

    typedef struct {
        int res;
        int found;
        int lat;
    } exp_t;

    vec_t vecs[10];
    exp_t sb[$];

    modular_log #(.N(N), .P(P)) dut (
        .clk    (clk),
        .rst    (rst),
        .ena    (ena),
        .start  (start),
        .base   (base),
        .target (target),
        .res    (res),
        .found  (found),
        .rdy    (rdy),
        .busy   (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input int act, input int req);
        checks++;
        if (act != req) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, req);
        end
    endtask

    function automatic int powmod(input int g, input int x);
        int r = 1;
        for (int i = 0; i < x; i++) r = (r * (g % P)) % P;
        return r;
    endfunction

    // Reference: smallest x in [0, P-2] with g^x == y, or -1.
    function automatic int ref_log(input int g, input int y);
        for (int x = 0; x <= P - 2; x++) begin
            if (powmod(g, x) == (y % P)) return x;
        end
        return -1;
    endfunction

    // Launch one search and wait for rdy. Latency counts clk edges after the start edge.
    task automatic run(input string name, input logic [N-1:0] b, input logic [N-1:0] t,
                       input int gap_at, input int gap_len, input bit poke_busy);
        exp_t e;
        int   lat;
        bit   got;
        @(negedge clk);
        base   = b;
        target = t;
        ena    = 1'b1;
        start  = 1'b1;
        @(posedge clk);
        @(negedge clk);
        start = 1'b0;
        lat   = 0;
        got   = 1'b0;
        while (lat < 300 && !got) begin
            ena   = !(gap_len > 0 && lat >= gap_at && lat < gap_at + gap_len);
            start = poke_busy && (lat == 3);
            @(posedge clk);
            lat++;
            @(negedge clk);
            if (rdy) got = 1'b1;
        end
        ena   = 1'b1;
        start = 1'b0;
        e = sb.pop_front();
        if (!got) begin
            check({name, " rdy_timeout"}, 0, 1);
        end else begin
            check({name, " res"}, int'(res), e.res);
            check({name, " found"}, int'(found), e.found);
            check({name, " latency"}, lat, e.lat);
            check({name, " busy_at_rdy"}, int'(busy), 0);
        end
        @(posedge clk);
        @(negedge clk);
        check({name, " rdy_one_cycle"}, int'(rdy), 0);
        check({name, " stays_idle"}, int'(busy), 0);
    endtask

    initial begin
        int   lat;
        bit   saw;
        exp_t e;

        vecs[0] = '{b: 8'd3,   t: 8'd65,  res: 5,  found: 1, lat: 7};
        vecs[1] = '{b: 8'd3,   t: 8'd1,   res: 0,  found: 1, lat: 2};
        vecs[2] = '{b: 8'd92,  t: 8'd154, res: 5,  found: 1, lat: 7};
        vecs[3] = '{b: 8'd3,   t: 8'd0,   res: 0,  found: 0, lat: 89};
        vecs[4] = '{b: 8'd0,   t: 8'd0,   res: 1,  found: 1, lat: 3};
        vecs[5] = '{b: 8'd0,   t: 8'd1,   res: 0,  found: 1, lat: 2};
        vecs[6] = '{b: 8'd0,   t: 8'd5,   res: 0,  found: 0, lat: 89};
        vecs[7] = '{b: 8'd1,   t: 8'd2,   res: 0,  found: 0, lat: 89};
        vecs[8] = '{b: 8'd89,  t: 8'd178, res: 1,  found: 1, lat: 3};
        vecs[9] = '{b: 8'd3,   t: 8'd42,  res: 10, found: 1, lat: 12};

        rst    = 1'b1;
        ena    = 1'b1;
        start  = 1'b0;
        base   = '0;
        target = '0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("reset res", int'(res), 0);
        check("reset found", int'(found), 0);
        check("reset rdy", int'(rdy), 0);
        check("reset busy", int'(busy), 0);
        rst = 1'b0;
        @(negedge clk);

        for (int i = 0; i < 10; i++) begin
            sb.push_back('{res: vecs[i].res, found: vecs[i].found, lat: vecs[i].lat});
            run($sformatf("vec%0d", i), vecs[i].b, vecs[i].t, 0, 0, 1'b0);
        end

        // ena low for 5 cycles mid-search plus a start pulse while busy.
        sb.push_back('{res: 5, found: 1, lat: 12});
        run("ena_gap", 8'd3, 8'd65, 3, 5, 1'b1);

        // res/found hold through INIT and search; async reset clears them mid-search.
        @(negedge clk);
        base   = 8'd3;
        target = 8'd0;
        start  = 1'b1;
        @(posedge clk);
        @(negedge clk);
        start = 1'b0;
        repeat (10) @(negedge clk);
        check("hold res", int'(res), 5);
        check("hold found", int'(found), 1);
        check("busy mid", int'(busy), 1);
        #2 rst = 1'b1;
        #1;
        check("async rst res", int'(res), 0);
        check("async rst found", int'(found), 0);
        check("async rst busy", int'(busy), 0);
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
        saw = 1'b0;
        for (int i = 0; i < 100; i++) begin
            @(negedge clk);
            if (rdy || busy) saw = 1'b1;
        end
        check("no rdy after rst", int'(saw), 0);
        sb.push_back('{res: 10, found: 1, lat: 12});
        run("post_rst", 8'd3, 8'd42, 0, 0, 1'b0);

        // Random sweep against an independent exponent model.
        for (int i = 0; i < 16; i++) begin
            int g, x, y, r;
            g = $urandom_range(0, 255);
            x = $urandom_range(0, P - 2);
            y = powmod(g, x);
            r = ref_log(g, y);
            sb.push_back('{res: r, found: 1, lat: r + 2});
            run($sformatf("rand%0d", i), 8'(g), 8'(y), 0, 0, 1'b0);
            check($sformatf("rand%0d pow", i), powmod(g, int'(res)), y);
            check($sformatf("rand%0d res_le_x", i), int'(int'(res) <= x), 1);
        end

        check("scoreboard empty", sb.size(), 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
